// File: rtl/tipi_xfer_ctrl_if.sv
// TI bus / RPi handshake signal bundle for the TIPI transfer controller.
// The slave modport is the controller view; master is the bus/RPi side.
interface tipi_xfer_ctrl_if;
    logic [0:15] ti_a;      // bit 0 is the MSB (TI numbering)
    logic [0:7]  ti_data;   // bit 0 is the MSB (TI numbering)
    logic        ti_memen;
    logic        ti_we;
    logic        dev_en;
    logic        rpi_ack;
    logic [7:0]  rpi_d;
    logic [7:0]  rpi_s;
    logic        rpi_req;
    logic        busy;
    logic        overrun;
    logic        timeout;

    modport slave (
        input  ti_a, ti_data, ti_memen, ti_we, dev_en, rpi_ack,
        output rpi_d, rpi_s, rpi_req, busy, overrun, timeout
    );

    modport master (
        output ti_a, ti_data, ti_memen, ti_we, dev_en, rpi_ack,
        input  rpi_d, rpi_s, rpi_req, busy, overrun, timeout
    );
endinterface

// File: rtl/tipi_xfer_ctrl.sv
// TIPI TI->RPi transfer controller: synchronises TI bus strobes, latches data and
// control bytes, and runs a four-phase req/ack handshake per control write with
// overrun, timeout and abort tracking.
module tipi_xfer_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] DATA_ADDR   = 16'h5fff,
    parameter logic [15:0] CTRL_ADDR   = 16'h5ffd,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input logic             clk,
    input logic             rst,
    tipi_xfer_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rpi_d_q, rpi_d_d;
    logic [7:0]         rpi_s_q, rpi_s_d;
    logic               rpi_req_q, rpi_req_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    logic [SYNC_STAGES-1:0] we_sync_q, memen_sync_q, ack_sync_q;
    logic                   we_prev_q;
    logic [15:0]            a_q;
    logic [7:0]             data_q;

    logic sync_we, sync_memen, sync_ack;
    logic we_fall, write_valid, cnt_last;

    assign sync_we    = we_sync_q[SYNC_STAGES-1];
    assign sync_memen = memen_sync_q[SYNC_STAGES-1];
    assign sync_ack   = ack_sync_q[SYNC_STAGES-1];

    assign we_fall     = we_prev_q && !sync_we;
    assign write_valid = we_fall && bus.dev_en && !sync_memen;
    assign cnt_last    = (cnt_q == CNT_LAST);

    // Strobe synchronisers and free-running bus capture; strobes idle inactive after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_sync_q    <= '1;
            memen_sync_q <= '1;
            ack_sync_q   <= '0;
            we_prev_q    <= 1'b1;
            a_q          <= '0;
            data_q       <= '0;
        end else begin
            we_sync_q    <= {we_sync_q[SYNC_STAGES-2:0], bus.ti_we};
            memen_sync_q <= {memen_sync_q[SYNC_STAGES-2:0], bus.ti_memen};
            ack_sync_q   <= {ack_sync_q[SYNC_STAGES-2:0], bus.rpi_ack};
            we_prev_q    <= sync_we;
            a_q          <= bus.ti_a;
            data_q       <= bus.ti_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, latch updates, sticky flags and phase counter.
    always_comb begin
        state_d   = state_q;
        rpi_d_d   = rpi_d_q;
        rpi_s_d   = rpi_s_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (write_valid) begin
                    if (a_q == DATA_ADDR) begin
                        rpi_d_d = data_q;
                    end else if (a_q == CTRL_ADDR) begin
                        rpi_s_d = data_q;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (!bus.dev_en) begin
                    state_d = StIdle;
                end else if (sync_ack) begin
                    state_d = StRelease;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StRelease: begin
                if (!bus.dev_en) begin
                    state_d = StIdle;
                end else if (!sync_ack) begin
                    state_d = StIdle;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any valid write outside IDLE is dropped, including one on the final RELEASE cycle.
        if (state_q != StIdle && write_valid) begin
            overrun_d = 1'b1;
        end

        // Disabling the device clears the sticky flags, overriding any set this cycle.
        if (!bus.dev_en) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end

        // Counter restarts on every state change and saturates rather than wrapping.
        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = '0;
        end else if (cnt_last) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Registered request; gating with dev_en drops it on the abort edge itself.
        rpi_req_d = (state_q == StReq) && bus.dev_en;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rpi_d_q   <= '0;
            rpi_s_q   <= '0;
            rpi_req_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rpi_d_q   <= rpi_d_d;
            rpi_s_q   <= rpi_s_d;
            rpi_req_q <= rpi_req_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.rpi_d   = rpi_d_q;
    assign bus.rpi_s   = rpi_s_q;
    assign bus.rpi_req = rpi_req_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.overrun = overrun_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tipi_xfer_ctrl.sv
// Directed bench for tipi_xfer_ctrl with a short timeout (16 cycles).
module tb_tipi_xfer_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    tipi_xfer_ctrl_if bus ();

    tipi_xfer_ctrl #(
        .SYNC_STAGES(2),
        .DATA_ADDR  (16'h5fff),
        .CTRL_ADDR  (16'h5ffd),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_write(input logic [15:0] addr, input logic [7:0] data);
        bus.ti_a     = addr;
        bus.ti_data  = data;
        bus.ti_memen = 1'b0;
        bus.ti_we    = 1'b0;
    endtask

    task automatic end_write();
        bus.ti_we    = 1'b1;
        bus.ti_memen = 1'b1;
    endtask

    // WE* low for four clocks, then one idle clock.
    task automatic ti_write(input logic [15:0] addr, input logic [7:0] data);
        start_write(addr, data);
        tick(4);
        end_write();
        tick(1);
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        rst          = 1'b1;
        bus.ti_a     = 16'h0000;
        bus.ti_data  = 8'h00;
        bus.ti_memen = 1'b1;
        bus.ti_we    = 1'b1;
        bus.dev_en   = 1'b0;
        bus.rpi_ack  = 1'b0;
        tick(2);

        // Reset state
        check("rst_rpi_d",   16'(bus.rpi_d),   16'h00);
        check("rst_rpi_s",   16'(bus.rpi_s),   16'h00);
        check("rst_req",     16'(bus.rpi_req), 16'h0);
        check("rst_busy",    16'(bus.busy),    16'h0);
        check("rst_overrun", 16'(bus.overrun), 16'h0);
        check("rst_timeout", 16'(bus.timeout), 16'h0);
        rst = 1'b0;
        bus.dev_en = 1'b1;
        tick(2);

        // 1: data write, latency SYNC_STAGES+1
        start_write(16'h5fff, 8'hA5);
        tick(2);
        check("t1_d_early", 16'(bus.rpi_d), 16'h00);
        tick(1);
        check("t1_d_latched", 16'(bus.rpi_d), 16'hA5);
        check("t1_no_req", 16'(bus.rpi_req), 16'h0);
        tick(1);
        end_write();
        tick(1);
        check("t1_not_busy", 16'(bus.busy), 16'h0);

        // 2: full handshake
        ti_write(16'h5ffd, 8'h3C);
        check("t2_rpi_s", 16'(bus.rpi_s), 16'h3C);
        check("t2_req_hi", 16'(bus.rpi_req), 16'h1);
        check("t2_busy", 16'(bus.busy), 16'h1);
        tick(9);
        bus.rpi_ack = 1'b1;
        tick(3);
        check("t2_req_held", 16'(bus.rpi_req), 16'h1);
        tick(1);
        check("t2_req_lo", 16'(bus.rpi_req), 16'h0);
        check("t2_busy_release", 16'(bus.busy), 16'h1);
        tick(6);
        bus.rpi_ack = 1'b0;
        tick(2);
        check("t2_busy_sync", 16'(bus.busy), 16'h1);
        tick(1);
        check("t2_idle", 16'(bus.busy), 16'h0);
        check("t2_no_timeout", 16'(bus.timeout), 16'h0);

        // 3: data write while busy is dropped
        ti_write(16'h5ffd, 8'h01);
        check("t3_rpi_s", 16'(bus.rpi_s), 16'h01);
        ti_write(16'h5fff, 8'h77);
        check("t3_d_unchanged", 16'(bus.rpi_d), 16'hA5);
        check("t3_overrun", 16'(bus.overrun), 16'h1);
        check("t3_still_req", 16'(bus.rpi_req), 16'h1);

        // 5b: dev_en drop during REQ aborts next clock and clears flags
        bus.dev_en = 1'b0;
        tick(1);
        check("t5_abort_req", 16'(bus.rpi_req), 16'h0);
        check("t5_abort_busy", 16'(bus.busy), 16'h0);
        check("t5_ovr_clr", 16'(bus.overrun), 16'h0);
        check("t5_no_timeout", 16'(bus.timeout), 16'h0);

        // 5a: writes ignored while disabled
        ti_write(16'h5ffd, 8'hFF);
        tick(2);
        check("t5_s_unchanged", 16'(bus.rpi_s), 16'h01);
        check("t5_no_req", 16'(bus.rpi_req), 16'h0);
        check("t5_no_busy", 16'(bus.busy), 16'h0);

        // 4: no ack -> timeout after 16 clk in REQ
        bus.dev_en = 1'b1;
        tick(1);
        ti_write(16'h5ffd, 8'h5A);
        check("t4_rpi_s", 16'(bus.rpi_s), 16'h5A);
        tick(13);
        check("t4_req_before", 16'(bus.rpi_req), 16'h1);
        check("t4_to_before", 16'(bus.timeout), 16'h0);
        tick(1);
        check("t4_timeout", 16'(bus.timeout), 16'h1);
        check("t4_busy_lo", 16'(bus.busy), 16'h0);
        tick(1);
        check("t4_req_lo", 16'(bus.rpi_req), 16'h0);

        // ack while IDLE is ignored
        bus.rpi_ack = 1'b1;
        tick(5);
        check("idle_ack_busy", 16'(bus.busy), 16'h0);
        check("idle_ack_req", 16'(bus.rpi_req), 16'h0);
        bus.rpi_ack = 1'b0;
        tick(3);

        // 6: async reset mid-handshake
        ti_write(16'h5ffd, 8'hC3);
        check("t6_req_hi", 16'(bus.rpi_req), 16'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_req", 16'(bus.rpi_req), 16'h0);
        check("t6_busy", 16'(bus.busy), 16'h0);
        check("t6_rpi_d", 16'(bus.rpi_d), 16'h00);
        check("t6_rpi_s", 16'(bus.rpi_s), 16'h00);
        check("t6_timeout", 16'(bus.timeout), 16'h0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t6_idle_busy", 16'(bus.busy), 16'h0);
        check("t6_idle_req", 16'(bus.rpi_req), 16'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
